// File: rtl/booth_pkg.sv
// Shared definitions for the booth multiply-accumulate block: FSM encoding,
// product width and the radix-4 booth partial-product and overflow helpers.
package booth_pkg;

    localparam int PROD_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Radix-4 booth digit selection: grp is {b[i+1], b[i], b[i-1]}.
    function automatic logic [PROD_W-1:0] booth_pp(input logic [2:0]        grp,
                                                   input logic [PROD_W-1:0] mcand);
        logic [PROD_W-1:0] pp;
        case (grp)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = PROD_W'(mcand << 1);
            3'b100:         pp = PROD_W'(~(mcand << 1) + 8'd1);
            3'b101, 3'b110: pp = PROD_W'(~mcand + 8'd1);
            default:        pp = 8'd0;
        endcase
        return pp;
    endfunction

    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/booth_accum_if.sv
// Operand/result handshake bundle for booth_accum; master drives operands and
// takes results, slave is the accumulator.
interface booth_accum_if #(parameter int ACC_W = 12);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             overflow;

    modport master (
        output clear, in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  clear, in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, overflow
    );

endinterface

// File: rtl/booth_accum_booth.sv
// Combinational 4x4 signed radix-4 booth multiplier producing an 8-bit product.
module booth
    import booth_pkg::*;
(
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    output logic [PROD_W-1:0] result
);

    logic [PROD_W-1:0] mcand_s;
    logic [PROD_W-1:0] pp0_s;
    logic [PROD_W-1:0] pp1_s;

    // Two booth digits cover the 4-bit multiplier; digit 1 is weighted by 4.
    always_comb begin
        mcand_s = {{4{a[3]}}, a};
        pp0_s   = booth_pp({b[1:0], 1'b0}, mcand_s);
        pp1_s   = booth_pp(b[3:1], mcand_s);
        result  = PROD_W'(pp0_s + PROD_W'(pp1_s << 2));
    end

endmodule

// File: rtl/booth_accum.sv
// Two-stage multiply-accumulate: registers each booth product, sums N_TERMS of
// them into a wrapping ACC_W accumulator and holds the total until taken.
module booth_accum
    import booth_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    booth_accum_if.slave bus
);

    localparam logic [CNT_W-1:0] TERMS_LAST = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] TERMS_PREV = CNT_W'(N_TERMS - 1);

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  in_cnt_r;
    logic [CNT_W-1:0]  term_cnt_r;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] prod_r;
    logic              pvalid_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  addend_s;
    logic [ACC_W-1:0]  acc_sum_s;
    logic              ovf_r;
    logic              step_ovf_s;
    logic              out_valid_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              handoff_s;
    logic              last_term_s;

    booth u_booth (
        .a      (bus.a),
        .b      (bus.b),
        .result (prod_s)
    );

    // Handshake decode and the stage-2 adder with its signed-overflow detect.
    always_comb begin
        in_ready_s  = (state_r != DONE) && (in_cnt_r < TERMS_LAST) && !bus.clear;
        accept_s    = bus.in_valid && in_ready_s;
        handoff_s   = out_valid_r && bus.out_ready;
        addend_s    = ACC_W'($signed(prod_r));
        acc_sum_s   = acc_r + addend_s;
        step_ovf_s  = add_ovf(acc_r[ACC_W-1], addend_s[ACC_W-1], acc_sum_s[ACC_W-1]);
        last_term_s = pvalid_r && (term_cnt_r == TERMS_PREV);
    end

    // Next-state logic; clear overrides every other input.
    always_comb begin
        state_s = state_r;
        if (bus.clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pvalid_r) begin
                        state_s = last_term_s ? DONE : ACCUM;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (last_term_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = ACCUM;
                    end
                end
                DONE: begin
                    if (handoff_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register; out_valid is registered alongside so it rises with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == DONE);
        end
    end

    // Product pipeline, accumulator, term counters and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r     <= 8'd0;
            pvalid_r   <= 1'b0;
            acc_r      <= '0;
            in_cnt_r   <= 4'd0;
            term_cnt_r <= 4'd0;
            ovf_r      <= 1'b0;
        end else if (bus.clear) begin
            prod_r     <= 8'd0;
            pvalid_r   <= 1'b0;
            acc_r      <= '0;
            in_cnt_r   <= 4'd0;
            term_cnt_r <= 4'd0;
            ovf_r      <= 1'b0;
        end else begin
            pvalid_r <= accept_s;
            if (accept_s) begin
                prod_r <= prod_s;
            end
            if (handoff_s) begin
                acc_r      <= '0;
                in_cnt_r   <= 4'd0;
                term_cnt_r <= 4'd0;
                ovf_r      <= 1'b0;
            end else begin
                if (accept_s) begin
                    in_cnt_r <= in_cnt_r + 4'd1;
                end
                if (pvalid_r) begin
                    acc_r      <= acc_sum_s;
                    term_cnt_r <= term_cnt_r + 4'd1;
                    ovf_r      <= ovf_r | step_ovf_s;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = acc_r;
    assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_booth_accum.sv
// Self-checking bench: a 12-bit and an 8-bit accumulator share one stimulus
// stream and are compared against an integer-arithmetic reference.
module tb_booth_accum;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clear     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a         = 4'd0;
    logic [3:0] b         = 4'd0;

    int checks   = 0;
    int failures = 0;
    int qa[$];
    int qb[$];
    int m12;
    int m8;
    bit o12;
    bit o8;
    logic [11:0] e12;
    logic [7:0]  e8;

    always #5 clk = ~clk;

    booth_accum_if #(.ACC_W(12)) bus12 ();
    booth_accum_if #(.ACC_W(8))  bus8 ();

    assign bus12.clear     = clear;
    assign bus12.in_valid  = in_valid;
    assign bus12.a         = a;
    assign bus12.b         = b;
    assign bus12.out_ready = out_ready;
    assign bus8.clear      = clear;
    assign bus8.in_valid   = in_valid;
    assign bus8.a          = a;
    assign bus8.b          = b;
    assign bus8.out_ready  = out_ready;

    booth_accum #(.N_TERMS(4), .ACC_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));
    booth_accum #(.N_TERMS(4), .ACC_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed sum wrapping at w bits, sticky flag when the true sum leaves range.
    task automatic model_add(input int p, input int w, inout int acc, inout bit ovf);
        int half;
        int s;
        half = 1 << (w - 1);
        s = acc + p;
        if (s > half - 1) begin
            ovf = 1'b1;
            s = s - 2 * half;
        end else if (s < -half) begin
            ovf = 1'b1;
            s = s + 2 * half;
        end
        acc = s;
    endtask

    task automatic send_all();
        for (int i = 0; i < qa.size(); i++) begin
            int n;
            n = 0;
            in_valid = 1'b1;
            a = 4'(qa[i]);
            b = 4'(qb[i]);
            while (!bus12.in_ready && n < 20) begin
                step();
                n++;
            end
            chk("accept_wait", 32'(n < 20), 32'd1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_batch(input string tag, input int hold);
        m12 = 0; m8 = 0; o12 = 1'b0; o8 = 1'b0;
        for (int i = 0; i < qa.size(); i++) begin
            model_add(qa[i] * qb[i], 12, m12, o12);
            model_add(qa[i] * qb[i], 8, m8, o8);
        end
        e12 = m12[11:0];
        e8  = m8[7:0];
        send_all();
        chk({tag, "_valid_t1"}, 32'(bus12.out_valid), 32'd0);
        step();
        chk({tag, "_valid_t2"}, 32'(bus12.out_valid), 32'd1);
        chk({tag, "_sum12"}, 32'(bus12.sum), 32'(e12));
        chk({tag, "_ovf12"}, 32'(bus12.overflow), 32'(o12));
        chk({tag, "_sum8"}, 32'(bus8.sum), 32'(e8));
        chk({tag, "_ovf8"}, 32'(bus8.overflow), 32'(o8));
        chk({tag, "_ready_done"}, 32'(bus12.in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(bus12.out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(bus12.sum), 32'(e12));
            chk({tag, "_hold_ready"}, 32'(bus12.in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_taken_valid"}, 32'(bus12.out_valid), 32'd0);
        chk({tag, "_taken_ready"}, 32'(bus12.in_ready), 32'd1);
        chk({tag, "_taken_sum"}, 32'(bus12.sum), 32'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(bus12.out_valid), 32'd0);
        chk("rst_sum", 32'(bus12.sum), 32'd0);
        chk("rst_ovf", 32'(bus12.overflow), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(bus12.in_ready), 32'd1);

        qa = '{2, 2, 2, 2};
        qb = '{-1, 6, -6, -1};
        run_batch("mixed", 0);

        qa = '{-8, -8, -8, -8};
        qb = '{-8, -8, -8, -8};
        run_batch("neg8_hold", 3);

        // Abort two terms into a batch; a pair offered alongside clear must be ignored.
        qa = '{5, -4};
        qb = '{3, 7};
        send_all();
        clear = 1'b1;
        in_valid = 1'b1;
        a = 4'd7;
        b = 4'd7;
        #1;
        chk("clear_ready", 32'(bus12.in_ready), 32'd0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_sum", 32'(bus12.sum), 32'd0);
        step();
        chk("clear_stale", 32'(bus12.sum), 32'd0);
        qa = '{1, 1, 1, 1};
        qb = '{1, 1, 1, 1};
        run_batch("after_clear", 0);

        qa = '{3, 3, 3};
        qb = '{3, 3, 3};
        send_all();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus12.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus12.sum), 32'd0);
        chk("midrst_ovf", 32'(bus8.overflow), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", 32'(bus12.in_ready), 32'd1);
        qa = '{3, 3, 3, 3};
        qb = '{3, 3, 3, 3};
        run_batch("after_rst", 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) begin
                logic signed [3:0] ra;
                logic signed [3:0] rb;
                ra = 4'($urandom_range(15, 0));
                rb = 4'($urandom_range(15, 0));
                qa.push_back(int'(ra));
                qb.push_back(int'(rb));
            end
            run_batch("rand", int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_accum.md
BOOTH_ACCUM -- requirements
Module: booth_accum

Interface
REQ-001 Parameter N_TERMS, default 4, SHALL set the number of products summed per result (legal 1..15).
REQ-002 Parameter ACC_W, default 12, SHALL set the accumulator and sum width (legal 8..16).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 clear  input  1  SHALL be a synchronous abort that discards the batch in progress.
REQ-006 in_valid  input  1  SHALL mark a valid operand pair.
REQ-007 in_ready  output  1  SHALL mark that the block accepts an operand pair this cycle.
REQ-008 a  input  4  SHALL be the signed two's-complement multiplicand.
REQ-009 b  input  4  SHALL be the signed two's-complement multiplier.
REQ-010 out_valid  output  1  SHALL mark that sum is valid.
REQ-011 out_ready  input  1  SHALL mark that the consumer takes sum this cycle.
REQ-012 sum  output  ACC_W  SHALL be the signed total of N_TERMS products.
REQ-013 overflow  output  1  SHALL flag signed overflow within the batch now presented on sum.

Function
REQ-014 The block SHALL form each product a*b as a signed 8-bit value (range -56..64) through the existing booth multiplier.
REQ-015 The block SHALL accept a pair in any cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL equal (state != DONE) and (accepted count < N_TERMS) and not clear.
REQ-017 Stage 1 SHALL register the accepted product and a valid bit on the next edge.
REQ-018 Stage 2 SHALL add the sign-extended registered product to the accumulator one edge later and increment the term count.
REQ-019 FSM states SHALL be IDLE (no term accumulated), ACCUM (1..N_TERMS-1 terms accumulated) and DONE (result held).
REQ-020 Transitions: IDLE->ACCUM on the first accumulate; ACCUM->DONE on the accumulate that makes the count N_TERMS (IDLE->DONE when N_TERMS=1); DONE->IDLE on out_valid and out_ready.
REQ-021 Latency: if the last pair is accepted in cycle t, out_valid SHALL be 1 from cycle t+2.
REQ-022 In DONE, out_valid SHALL be 1, and sum and overflow SHALL hold stable until out_ready is 1.
REQ-023 On the DONE->IDLE edge, the accumulator, both counts and overflow SHALL return to 0.
REQ-024 The accumulator SHALL wrap modulo 2^ACC_W; overflow SHALL be sticky and set by any addition whose operands share a sign that differs from the result's sign.
REQ-025 clear SHALL take priority over all other inputs: the next edge returns the FSM to IDLE and zeroes the accumulator, counts, pipeline valid and overflow.
REQ-026 A pair presented together with clear SHALL NOT be accepted.
REQ-027 out_valid and in_ready SHALL never both be 1 in the same cycle.

Reset
REQ-028 While rst_n is 0: state = IDLE, accumulator = 0, counts = 0, pipeline valid = 0, out_valid = 0, sum = 0, overflow = 0; in_ready = 1 from the first cycle after deassertion.
REQ-029 Reset asserted mid-batch SHALL discard all partial results with no output.

Structure
REQ-030 The FSM state encoding and the product width constant (8) SHALL live in the shared package booth_pkg.
REQ-031 booth_accum SHALL instantiate exactly one sub-module, the existing combinational booth (a, b -> result[7:0]).

Verification
REQ-032 Pairs (2,-1), (2,6), (2,-6), (2,-1), with out_ready=1 -> sum = 0xFFC (-4), overflow = 0, out_valid 2 cycles after the 4th accept.
REQ-033 Four pairs of (-8,-8) -> sum = 0x100 (256), overflow = 0.
REQ-034 ACC_W=8, four pairs of (-8,-8) -> sum = 0x00, overflow = 1.
REQ-035 out_ready held 0 for 3 cycles in DONE -> sum and out_valid stable, in_ready = 0; output accepted on the 4th cycle, then in_ready = 1.
REQ-036 clear after 2 accepts, then pairs (1,1) x4 -> sum = 4; no stale terms included.
REQ-037 rst_n pulsed low after 3 accepts -> all outputs 0 immediately; a fresh batch of (3,3) x4 -> sum = 36.
